// File: rtl/mode_ctl_rec_if.sv
// Regfile write port of the mode controller's note recorder.
//   wr_en    one-cycle write strobe, one per record
//   wr_addr  record address
//   wr_data  record contents, {note, dur}
//   rec_full record memory has been filled; no more records this session
// master: the recorder (mode_ctl_rec); slave: the regfile / observer.
interface mode_ctl_rec_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 13
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rec_full;

    modport master (output wr_en, output wr_addr, output wr_data, output rec_full);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  rec_full);
endinterface

// File: rtl/mode_ctl_rec.sv
// Mode controller with run-length note recorder.
// Steps through NMODES modes on a debounced pulse (wrapping to 0) and decodes
// every enable and the key routing from the mode register. In WRITING mode the
// key switches are recorded as {note, dur} records into the regfile port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode_step             one-cycle pulse, advances the mode
//   sw, play_sig          key switches / playback key vector
//   tick                  one-cycle duration time base
//   mode                  current mode code
//   music_box, electone,
//   writing, adj          mode enables
//   key_out               routed key vector
//   wr                    regfile write port + rec_full (master modport)
//
// mode code    | meaning
// 0            | music box: playback keys routed out, adjust enabled
// 1            | electone: live switches routed out
// 2            | writing: live switches routed out and recorded
// 3..NMODES-1  | idle: all enables low, keys silenced
module mode_ctl_rec #(
    parameter int NMODES = 3,
    parameter int KEY_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8,
    parameter int NOTE_W = $clog2(KEY_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode_step,
    input  logic [KEY_W-1:0]           sw,
    input  logic [KEY_W-1:0]           play_sig,
    input  logic                       tick,
    output logic [$clog2(NMODES)-1:0]  mode,
    output logic                       music_box,
    output logic                       electone,
    output logic                       writing,
    output logic                       adj,
    output logic [KEY_W-1:0]           key_out,
    mode_ctl_rec_if.master             wr
);
    localparam int MODE_W = $clog2(NMODES);
    localparam logic [MODE_W-1:0] MODE_MUSIC    = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_ELECTONE = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_WRITING  = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_LAST     = MODE_W'(NMODES - 1);
    localparam logic [DUR_W-1:0]  DUR_MAX       = {DUR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_MAX      = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        K_MUSIC,
        K_ELECTONE,
        K_WRITING,
        K_IDLE
    } mode_kind_t;

    logic [MODE_W-1:0] mode_q, mode_d;
    mode_kind_t        kind;

    logic [NOTE_W-1:0]       cur_note_q, cur_note_d;
    logic [DUR_W-1:0]        dur_q, dur_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rec_full_q, rec_full_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [NOTE_W+DUR_W-1:0] wr_data_q, wr_data_d;
    logic [NOTE_W-1:0]       note_enc;
    logic                    in_wr, entering, emit;

    // Mode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_MUSIC;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_step) begin
            mode_d = (mode_q == MODE_LAST) ? MODE_MUSIC : mode_q + MODE_W'(1);
        end
    end

    // Mode decode; codes past WRITING all collapse to idle
    always_comb begin
        kind = K_IDLE;
        case (mode_q)
            MODE_MUSIC:    kind = K_MUSIC;
            MODE_ELECTONE: kind = K_ELECTONE;
            MODE_WRITING:  kind = K_WRITING;
            default:       kind = K_IDLE;
        endcase
    end

    always_comb begin
        music_box = 1'b0;
        electone  = 1'b0;
        writing   = 1'b0;
        adj       = 1'b0;
        key_out   = '0;
        case (kind)
            K_MUSIC: begin
                music_box = 1'b1;
                adj       = 1'b1;
                key_out   = play_sig;
            end
            K_ELECTONE: begin
                electone = 1'b1;
                key_out  = sw;
            end
            K_WRITING: begin
                writing = 1'b1;
                key_out = sw;
            end
            default: ;
        endcase
    end

    assign mode = mode_q;

    // Lowest set switch wins; 0 encodes a rest
    always_comb begin
        note_enc = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (sw[i]) begin
                note_enc = NOTE_W'(i + 1);
            end
        end
    end

    assign in_wr    = (mode_q == MODE_WRITING);
    assign entering = mode_step && !in_wr && (mode_d == MODE_WRITING);

    always_comb begin
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        addr_d     = addr_q;
        rec_full_d = rec_full_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        emit       = 1'b0;

        if (entering) begin
            addr_d     = '0;
            cur_note_d = note_enc;
            dur_d      = '0;
            rec_full_d = 1'b0;
        end else if (in_wr) begin
            if (mode_step) begin
                // Exit flushes the note in progress; a concurrent change is ignored
                emit = !rec_full_q;
            end else if (note_enc != cur_note_q) begin
                // A tick landing on a change is dropped: new note starts at 0
                emit       = !rec_full_q;
                cur_note_d = note_enc;
                dur_d      = '0;
            end else if (tick && (dur_q != DUR_MAX)) begin
                dur_d = dur_q + DUR_W'(1);
            end
        end

        // Record holds the note as it was before this edge
        if (emit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {cur_note_q, dur_q};
            if (addr_q == ADDR_MAX) begin
                rec_full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_note_q <= '0;
            dur_q      <= '0;
            addr_q     <= '0;
            rec_full_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            cur_note_q <= cur_note_d;
            dur_q      <= dur_d;
            addr_q     <= addr_d;
            rec_full_q <= rec_full_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr.wr_en    = wr_en_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign wr.rec_full = rec_full_q;

endmodule

// File: tb/tb_mode_ctl_rec.sv
// Bench for mode_ctl_rec: instance A (NMODES=3, ADDR_W=8) covers mode cycling,
// recording, duration saturation, exit and reset; instance B (NMODES=5,
// ADDR_W=2) covers idle modes and the full-memory condition.
module tb_mode_ctl_rec;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A
    logic        a_rst_n, a_step, a_tick;
    logic [15:0] a_sw, a_play, a_key;
    logic [1:0]  a_mode;
    logic        a_mb, a_el, a_wri, a_adj;
    mode_ctl_rec_if #(.ADDR_W(8), .DATA_W(13)) wa ();

    mode_ctl_rec #(.NMODES(3), .KEY_W(16), .ADDR_W(8), .DUR_W(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .mode_step(a_step), .sw(a_sw), .play_sig(a_play),
        .tick(a_tick), .mode(a_mode), .music_box(a_mb), .electone(a_el), .writing(a_wri),
        .adj(a_adj), .key_out(a_key), .wr(wa)
    );

    // Instance B
    logic        b_rst_n, b_step, b_tick;
    logic [15:0] b_sw, b_play, b_key;
    logic [2:0]  b_mode;
    logic        b_mb, b_el, b_wri, b_adj;
    mode_ctl_rec_if #(.ADDR_W(2), .DATA_W(13)) wb ();

    mode_ctl_rec #(.NMODES(5), .KEY_W(16), .ADDR_W(2), .DUR_W(8)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .mode_step(b_step), .sw(b_sw), .play_sig(b_play),
        .tick(b_tick), .mode(b_mode), .music_box(b_mb), .electone(b_el), .writing(b_wri),
        .adj(b_adj), .key_out(b_key), .wr(wb)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(2);
        n_cmp++; if (a_mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode got %0d want 0", a_mode); end
        n_cmp++; if ({a_mb, a_el, a_wri, a_adj} !== 4'b1001) begin n_bad++; $display("FAIL reset_enables got %b want 1001", {a_mb, a_el, a_wri, a_adj}); end
        n_cmp++; if (a_key !== a_play) begin n_bad++; $display("FAIL reset_key got %h want %h", a_key, a_play); end
        n_cmp++; if ({wa.wr_en, wa.rec_full} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_en_full got %b want 00", {wa.wr_en, wa.rec_full}); end
        n_cmp++; if (wa.wr_addr !== 8'd0 || wa.wr_data !== 13'd0) begin n_bad++; $display("FAIL reset_wr_addr_data got %h/%h want 0/0", wa.wr_addr, wa.wr_data); end
        n_cmp++; if (b_mode !== 3'd0 || wb.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_b got mode %0d wr_en %b want 0 0", b_mode, wb.wr_en); end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_mode_cycle;
        logic [1:0]  exp_mode [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        logic [3:0]  exp_en   [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b0100};
        logic [15:0] exp_key  [4];
        a_play = 16'hA5A5;
        a_sw   = 16'h0F0F;
        exp_key = '{16'h0F0F, 16'h0F0F, 16'hA5A5, 16'h0F0F};
        for (int i = 0; i < 4; i++) begin
            a_step = 1'b1;
            cyc(1);
            a_step = 1'b0;
            n_cmp++; if (a_mode !== exp_mode[i]) begin n_bad++; $display("FAIL cycle_mode[%0d] got %0d want %0d", i, a_mode, exp_mode[i]); end
            n_cmp++; if ({a_mb, a_el, a_wri, a_adj} !== exp_en[i]) begin n_bad++; $display("FAIL cycle_enables[%0d] got %b want %b", i, {a_mb, a_el, a_wri, a_adj}, exp_en[i]); end
            n_cmp++; if (a_key !== exp_key[i]) begin n_bad++; $display("FAIL cycle_key[%0d] got %h want %h", i, a_key, exp_key[i]); end
            cyc(1);
        end
    endtask

    task automatic test_idle_modes;
        logic [2:0]  exp_mode [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [3:0]  exp_en   [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b1001};
        logic [15:0] exp_key  [5];
        b_play = 16'h1234;
        b_sw   = 16'h8001;
        exp_key = '{16'h8001, 16'h8001, 16'h0000, 16'h0000, 16'h1234};
        for (int i = 0; i < 5; i++) begin
            b_step = 1'b1;
            cyc(1);
            b_step = 1'b0;
            n_cmp++; if (b_mode !== exp_mode[i]) begin n_bad++; $display("FAIL idle_mode[%0d] got %0d want %0d", i, b_mode, exp_mode[i]); end
            n_cmp++; if ({b_mb, b_el, b_wri, b_adj} !== exp_en[i]) begin n_bad++; $display("FAIL idle_enables[%0d] got %b want %b", i, {b_mb, b_el, b_wri, b_adj}, exp_en[i]); end
            n_cmp++; if (b_key !== exp_key[i]) begin n_bad++; $display("FAIL idle_key[%0d] got %h want %h", i, b_key, exp_key[i]); end
            cyc(1);
        end
    endtask

    // A is in mode 1 here
    task automatic test_record;
        a_sw   = 16'h0004;
        a_step = 1'b1;
        cyc(1);
        a_step = 1'b0;
        n_cmp++; if (a_mode !== 2'd2 || a_wri !== 1'b1) begin n_bad++; $display("FAIL rec_enter got mode %0d writing %b want 2 1", a_mode, a_wri); end
        a_tick = 1'b1;
        cyc(5);
        a_tick = 1'b0;
        n_cmp++; if (wa.wr_en !== 1'b0) begin n_bad++; $display("FAIL rec_no_write_on_tick got %b want 0", wa.wr_en); end
        a_sw = 16'h0010;
        cyc(1);
        n_cmp++; if (wa.wr_en !== 1'b1) begin n_bad++; $display("FAIL rec1_wr_en got %b want 1", wa.wr_en); end
        n_cmp++; if (wa.wr_addr !== 8'd0) begin n_bad++; $display("FAIL rec1_addr got %0d want 0", wa.wr_addr); end
        n_cmp++; if (wa.wr_data !== 13'h305) begin n_bad++; $display("FAIL rec1_data got %h want 305", wa.wr_data); end
        cyc(1);
        n_cmp++; if (wa.wr_en !== 1'b0) begin n_bad++; $display("FAIL rec1_pulse_width got %b want 0", wa.wr_en); end
        a_tick = 1'b1;
        cyc(2);
        a_tick = 1'b0;
        a_sw = 16'h0001;
        cyc(1);
        n_cmp++; if (wa.wr_en !== 1'b1 || wa.wr_addr !== 8'd1) begin n_bad++; $display("FAIL rec2_addr got en %b addr %0d want 1 1", wa.wr_en, wa.wr_addr); end
        n_cmp++; if (wa.wr_data !== 13'h502) begin n_bad++; $display("FAIL rec2_data got %h want 502", wa.wr_data); end
    endtask

    // cur_note=1, dur=0, addr=2
    task automatic test_change_tick;
        a_tick = 1'b1;
        cyc(2);
        a_sw = 16'h0002;
        cyc(1);
        a_tick = 1'b0;
        n_cmp++; if (wa.wr_en !== 1'b1 || wa.wr_addr !== 8'd2 || wa.wr_data !== 13'h102) begin n_bad++; $display("FAIL chg_tick_rec got en %b addr %0d data %h want 1 2 102", wa.wr_en, wa.wr_addr, wa.wr_data); end
        a_sw = 16'h0008;
        cyc(1);
        n_cmp++; if (wa.wr_addr !== 8'd3 || wa.wr_data !== 13'h200) begin n_bad++; $display("FAIL chg_tick_dropped got addr %0d data %h want 3 200", wa.wr_addr, wa.wr_data); end
        a_tick = 1'b1;
        cyc(300);
        a_tick = 1'b0;
        a_sw = 16'h0000;
        cyc(1);
        n_cmp++; if (wa.wr_en !== 1'b1 || wa.wr_addr !== 8'd4 || wa.wr_data !== 13'h4FF) begin n_bad++; $display("FAIL dur_saturate got en %b addr %0d data %h want 1 4 4ff", wa.wr_en, wa.wr_addr, wa.wr_data); end
    endtask

    // cur_note=0, dur=0, addr=5
    task automatic test_exit_coincident;
        int writes;
        a_tick = 1'b1;
        cyc(3);
        a_tick = 1'b0;
        a_sw   = 16'h0040;
        a_step = 1'b1;
        cyc(1);
        a_step = 1'b0;
        n_cmp++; if (a_mode !== 2'd0) begin n_bad++; $display("FAIL exit_mode got %0d want 0", a_mode); end
        n_cmp++; if (wa.wr_en !== 1'b1 || wa.wr_addr !== 8'd5 || wa.wr_data !== 13'h003) begin n_bad++; $display("FAIL exit_rec got en %b addr %0d data %h want 1 5 003", wa.wr_en, wa.wr_addr, wa.wr_data); end
        writes = 0;
        a_sw = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (wa.wr_en === 1'b1) writes++;
            a_sw = a_sw ^ 16'h0003;
        end
        n_cmp++; if (writes !== 0) begin n_bad++; $display("FAIL exit_no_more_writes got %0d want 0", writes); end
    endtask

    // B is in mode 0 here
    task automatic test_full;
        b_step = 1'b1;
        cyc(1);
        b_step = 1'b0;
        cyc(1);
        b_sw   = 16'h0001;
        b_step = 1'b1;
        cyc(1);
        b_step = 1'b0;
        n_cmp++; if (b_mode !== 3'd2 || wb.rec_full !== 1'b0) begin n_bad++; $display("FAIL full_enter got mode %0d full %b want 2 0", b_mode, wb.rec_full); end
        for (int k = 0; k < 5; k++) begin
            b_sw = 16'h0002 << k;
            cyc(1);
            if (k < 4) begin
                n_cmp++; if (wb.wr_en !== 1'b1 || wb.wr_addr !== 2'(k)) begin n_bad++; $display("FAIL full_write[%0d] got en %b addr %0d want 1 %0d", k, wb.wr_en, wb.wr_addr, k); end
                n_cmp++; if (wb.wr_data !== 13'((k + 1) << 8)) begin n_bad++; $display("FAIL full_data[%0d] got %h want %h", k, wb.wr_data, 13'((k + 1) << 8)); end
                n_cmp++; if (wb.rec_full !== (k == 3)) begin n_bad++; $display("FAIL full_flag[%0d] got %b want %b", k, wb.rec_full, (k == 3)); end
            end else begin
                n_cmp++; if (wb.wr_en !== 1'b0 || wb.rec_full !== 1'b1) begin n_bad++; $display("FAIL full_blocked got en %b full %b want 0 1", wb.wr_en, wb.rec_full); end
            end
        end
        b_step = 1'b1;
        cyc(1);
        b_step = 1'b0;
        n_cmp++; if (b_mode !== 3'd3 || wb.wr_en !== 1'b0) begin n_bad++; $display("FAIL full_no_exit_rec got mode %0d en %b want 3 0", b_mode, wb.wr_en); end
        for (int i = 0; i < 3; i++) begin
            b_step = 1'b1;
            cyc(1);
            b_step = 1'b0;
        end
        n_cmp++; if (b_mode !== 3'd1 || wb.rec_full !== 1'b1) begin n_bad++; $display("FAIL full_holds got mode %0d full %b want 1 1", b_mode, wb.rec_full); end
        b_step = 1'b1;
        cyc(1);
        b_step = 1'b0;
        n_cmp++; if (b_mode !== 3'd2 || wb.rec_full !== 1'b0) begin n_bad++; $display("FAIL full_reentry_clear got mode %0d full %b want 2 0", b_mode, wb.rec_full); end
    endtask

    // A is in mode 0, a_sw toggles around 16'h0100 (note 9)
    task automatic test_reset_mid;
        int writes;
        a_sw   = 16'h0100;
        a_step = 1'b1;
        cyc(2);
        a_step = 1'b0;
        n_cmp++; if (a_mode !== 2'd2) begin n_bad++; $display("FAIL rstmid_enter got %0d want 2", a_mode); end
        a_sw = 16'h0001;
        cyc(1);
        n_cmp++; if (wa.wr_en !== 1'b1 || wa.wr_addr !== 8'd0 || wa.wr_data !== 13'h900) begin n_bad++; $display("FAIL rstmid_pre_rec got en %b addr %0d data %h want 1 0 900", wa.wr_en, wa.wr_addr, wa.wr_data); end
        a_tick = 1'b1;
        #2;
        a_rst_n = 1'b0;
        #1;
        n_cmp++; if (a_mode !== 2'd0 || {a_mb, a_el, a_wri, a_adj} !== 4'b1001) begin n_bad++; $display("FAIL rstmid_mode got mode %0d en %b want 0 1001", a_mode, {a_mb, a_el, a_wri, a_adj}); end
        n_cmp++; if (wa.wr_en !== 1'b0 || wa.wr_addr !== 8'd0 || wa.wr_data !== 13'd0 || wa.rec_full !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr got en %b addr %0d data %h full %b want 0 0 0 0", wa.wr_en, wa.wr_addr, wa.wr_data, wa.rec_full); end
        n_cmp++; if (a_key !== a_play) begin n_bad++; $display("FAIL rstmid_key got %h want %h", a_key, a_play); end
        writes = 0;
        a_sw = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (wa.wr_en === 1'b1) writes++;
        end
        a_tick  = 1'b0;
        a_rst_n = 1'b1;
        cyc(2);
        if (wa.wr_en === 1'b1) writes++;
        n_cmp++; if (writes !== 0 || a_mode !== 2'd0) begin n_bad++; $display("FAIL rstmid_no_flush got writes %0d mode %0d want 0 0", writes, a_mode); end
    endtask

    initial begin
        a_rst_n = 1'b0; a_step = 1'b0; a_tick = 1'b0; a_sw = 16'h0000; a_play = 16'h5A5A;
        b_rst_n = 1'b0; b_step = 1'b0; b_tick = 1'b0; b_sw = 16'h0000; b_play = 16'h0000;
        test_reset;
        test_mode_cycle;
        test_idle_modes;
        test_record;
        test_change_tick;
        test_exit_coincident;
        test_full;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end
endmodule
